slave_arbitrate_interface_rd: RTL and testbench

- Read-side slave port of the DDR arbiter. Drains one stored frame from DDR into a downstream output FIFO (Ethernet/SD sink) in fixed 256-word bursts.
- Raises a read request whenever the output FIFO has room for a full burst, and advances the frame address after each granted burst.
- Flags frame completion at MAXADDR and re-arms on the next consumer frame-start pulse.

---
 rtl/slave_arbitrate_interface_rd_if.sv | 24 ++
 rtl/slave_arbitrate_interface_rd.sv | 156 +++++++++++++++
 tb/tb_slave_arbitrate_interface_rd.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/slave_arbitrate_interface_rd_if.sv
// slave_arbitrate_interface_rd_if: handshake/bus bundle between the read slave, its output FIFO and the DDR arbiter
// slave modport: the read slave (consumes FIFO status and grant, drives request/address/status)
// master modport: the arbiter/FIFO side (drives frame_start, FIFO status, grant and bank)
interface slave_arbitrate_interface_rd_if;
  logic        frame_start;
  logic        fifo_full_flag;
  logic        fifo_empty_flag;
  logic [10:0] fifo_len;
  logic        slave_req;
  logic        arbitrate_valid;
  logic [1:0]  slave_rdbank;
  logic [24:0] slave_raddr;
  logic [9:0]  slave_rburst_len;
  logic        slave_frame_finished;
  logic        slave_rd_timeout;
  modport slave (
    input  frame_start, fifo_full_flag, fifo_empty_flag, fifo_len, arbitrate_valid, slave_rdbank,
    output slave_req, slave_raddr, slave_rburst_len, slave_frame_finished, slave_rd_timeout
  );
  modport master (
    output frame_start, fifo_full_flag, fifo_empty_flag, fifo_len, arbitrate_valid, slave_rdbank,
    input  slave_req, slave_raddr, slave_rburst_len, slave_frame_finished, slave_rd_timeout
  );
endinterface

// File: rtl/slave_arbitrate_interface_rd.sv
// slave_arbitrate_interface_rd: DDR arbiter read slave draining one frame into an output FIFO in fixed bursts
// Ports: ddr_clk (clock), sys_rstn (async active-low reset), bus (slave modport: frame_start, FIFO status,
//   grant/bank in; request, {bank,PARAM_BIT,SLAVE_NUMBER,addr} address, burst length, frame-finished, timeout out)
// Optional: define RD_TIMEOUT_EN to add the grant-stall watchdog driving slave_rd_timeout (else tied low).
module slave_arbitrate_interface_rd #(
  parameter logic [3:0]  SLAVE_NUMBER = 4'b0000,
  parameter logic        PARAM_BIT    = 1'b0,
  parameter logic [17:0] MAXADDR      = 18'd245_760,
  parameter logic [9:0]  BURST_LEN    = 10'd256,
  parameter logic [10:0] FIFO_DEPTH   = 11'd1024
) (
  input logic                            ddr_clk,
  input logic                            sys_rstn,
  slave_arbitrate_interface_rd_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, WAIT_ROOM, REQ, BUSY, DONE} state_e;
  localparam logic [10:0] ROOM = FIFO_DEPTH - {1'b0, BURST_LEN};
  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [17:0] raddr_q, raddr_d;
  logic [1:0]  bank_q, bank_d;
  logic [1:0]  pbank_q, pbank_d;
  logic        pend_q, pend_d;
  logic        fin_q, fin_d;
  logic [9:0]  blen_q, blen_d;
  logic        v0_q, v1_q;
  logic        valid_neg, room, start;
  logic [1:0]  start_bank;
  logic [17:0] raddr_nx;
`ifdef RD_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
`endif
  // grant end is seen two cycles late through the d0/d1 pipeline
  assign valid_neg = v1_q & ~v0_q;
  // an empty FIFO always has room; otherwise a whole burst must fit
  assign room      = ~bus.fifo_full_flag & (bus.fifo_empty_flag | (bus.fifo_len <= ROOM));
  assign raddr_nx  = raddr_q + {8'd0, BURST_LEN};
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    raddr_d    = raddr_q;
    bank_d     = bank_q;
    pbank_d    = pbank_q;
    pend_d     = pend_q;
    fin_d      = fin_q;
    blen_d     = BURST_LEN;
    start      = 1'b0;
    start_bank = bus.slave_rdbank;
    case (state_q)
      IDLE:      start = bus.frame_start;
      WAIT_ROOM: begin
        if (bus.frame_start) start = 1'b1;
        else if (room) begin
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // a grant in the same cycle as frame_start wins; the pulse becomes pending
        if (bus.arbitrate_valid) begin
          req_d   = 1'b0;
          state_d = BUSY;
          pend_d  = bus.frame_start;
          pbank_d = bus.slave_rdbank;
        end else if (bus.frame_start) start = 1'b1;
      end
      BUSY: begin
        if (bus.frame_start) begin
          pend_d  = 1'b1;
          pbank_d = bus.slave_rdbank;
        end
        if (valid_neg) begin
          if (pend_q || bus.frame_start) begin
            start      = 1'b1;
            start_bank = bus.frame_start ? bus.slave_rdbank : pbank_q;
          end else begin
            raddr_d = raddr_nx;
            state_d = (raddr_nx == MAXADDR) ? DONE : WAIT_ROOM;
          end
        end
      end
      DONE: begin
        if (bus.frame_start) start = 1'b1;
        else begin
          fin_d   = 1'b1;
          raddr_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      raddr_d = '0;
      bank_d  = start_bank;
      fin_d   = 1'b0;
      pend_d  = 1'b0;
      req_d   = 1'b0;
      state_d = WAIT_ROOM;
    end
`ifdef RD_TIMEOUT_EN
    tmo_d = bus.frame_start ? 1'b0 : tmo_q;
    if (cnt_q == 16'hFFFF) begin
      tmo_d   = 1'b1;
      req_d   = 1'b0;
      fin_d   = 1'b1;
      pend_d  = 1'b0;
      state_d = IDLE;
    end
    cnt_d = (state_d != state_q || !(state_q inside {REQ, BUSY})) ? 16'd0 : cnt_q + 16'd1;
`endif
  end
  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      raddr_q <= '0;
      bank_q  <= '0;
      pbank_q <= '0;
      pend_q  <= 1'b0;
      fin_q   <= 1'b1;
      blen_q  <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      raddr_q <= raddr_d;
      bank_q  <= bank_d;
      pbank_q <= pbank_d;
      pend_q  <= pend_d;
      fin_q   <= fin_d;
      blen_q  <= blen_d;
      v0_q    <= bus.arbitrate_valid;
      v1_q    <= v0_q;
    end
  end
`ifdef RD_TIMEOUT_EN
  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign bus.slave_rd_timeout = tmo_q;
`else
  assign bus.slave_rd_timeout = 1'b0;
`endif
  assign bus.slave_req            = req_q;
  assign bus.slave_raddr          = {bank_q, PARAM_BIT, SLAVE_NUMBER, raddr_q};
  assign bus.slave_rburst_len     = blen_q;
  assign bus.slave_frame_finished = fin_q;
endmodule

// File: tb/tb_slave_arbitrate_interface_rd.sv
// tb_slave_arbitrate_interface_rd: bench acting as arbiter and output FIFO, checked against a burst-level frame model
module tb_slave_arbitrate_interface_rd;
  localparam int MAXA = 245760;
  localparam int BL   = 256;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_ok  = 0;
  int exp_addr = 0;
  logic [1:0] exp_bank = 2'b00;
  bit done;
  int cnt;
  logic [1:0] fb;
  slave_arbitrate_interface_rd_if bus ();
  slave_arbitrate_interface_rd dut (.ddr_clk(clk), .sys_rstn(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] exp_raddr();
    return {7'd0, exp_bank, 1'b0, 4'b0000, 18'(exp_addr)};
  endfunction
  task automatic set_len(input int l);
    bus.fifo_len        = 11'(l);
    bus.fifo_empty_flag = (l == 0);
  endtask
  task automatic pulse(input logic [1:0] b);
    bus.slave_rdbank = b;
    bus.frame_start  = 1'b1;
    step();
    bus.frame_start  = 1'b0;
    bus.slave_rdbank = 2'($urandom);
  endtask
  task automatic wait_req();
    for (int i = 0; i < 16 && !bus.slave_req; i++) step();
    check("req_seen", bus.slave_req, 1);
  endtask
  // ev: 0 plain, 1 FIFO-room hold-off, 2 restart while requesting, 3 restart mid-burst,
  //     4 two pulses mid-burst, 5 restart on the grant-end cycle
  task automatic do_burst(input int ev, output bit fin);
    logic [1:0] nb;
    fin = 1'b0;
    nb  = 2'($urandom);
    wait_req();
    check("req_addr", bus.slave_raddr, exp_raddr());
    check("busy_finished", bus.slave_frame_finished, 0);
    if (ev == 2) begin
      pulse(nb);
      check("req_drop_on_restart", bus.slave_req, 0);
      exp_addr = 0;
      exp_bank = nb;
      return;
    end
    bus.arbitrate_valid = 1'b1;
    step();
    check("req_drop_on_grant", bus.slave_req, 0);
    if (ev == 3 || ev == 4) pulse(nb);
    if (ev == 4) begin
      step();
      pulse(nb);
    end
    bus.slave_rdbank = 2'($urandom);
    step($urandom_range(1, 4));
    bus.arbitrate_valid = 1'b0;
    if (ev == 1 && exp_addr + BL != MAXA) set_len(800);
    else set_len($urandom_range(0, 768));
    step();
    if (ev == 5) begin
      bus.slave_rdbank = nb;
      bus.frame_start  = 1'b1;
    end
    step();
    bus.frame_start = 1'b0;
    if (ev >= 3) begin
      exp_addr = 0;
      exp_bank = nb;
    end else exp_addr += BL;
    if (exp_addr == MAXA) begin
      step();
      fin = 1'b1;
      exp_addr = 0;
      check("frame_finished", bus.slave_frame_finished, 1);
      check("addr_cleared", bus.slave_raddr, exp_raddr());
      check("no_req_after_frame", bus.slave_req, 0);
    end else if (ev == 1) begin
      step(5);
      check("no_req_without_room", bus.slave_req, 0);
      bus.fifo_full_flag = 1'b1;
      set_len(768);
      step(4);
      check("no_req_when_full", bus.slave_req, 0);
      bus.fifo_full_flag = 1'b0;
      step();
      check("req_on_room", bus.slave_req, 1);
      set_len(0);
    end
  endtask
  initial begin
    bus.frame_start     = 1'b0;
    bus.fifo_full_flag  = 1'b0;
    bus.arbitrate_valid = 1'b0;
    bus.slave_rdbank    = 2'b00;
    set_len(0);
    #2 rst_n = 1'b0;
    step(3);
    check("rst_req", bus.slave_req, 0);
    check("rst_finished", bus.slave_frame_finished, 1);
    check("rst_burst_len", bus.slave_rburst_len, 0);
    check("rst_raddr", bus.slave_raddr, 0);
    check("rst_timeout", bus.slave_rd_timeout, 0);
    rst_n = 1'b1;
    step();
    check("burst_len", bus.slave_rburst_len, BL);
    step(3);
    check("idle_req", bus.slave_req, 0);
    check("idle_finished", bus.slave_frame_finished, 1);
    exp_bank = 2'b10;
    exp_addr = 0;
    pulse(2'b10);
    step();
    check("req_two_cycles", bus.slave_req, 1);
    check("first_raddr", bus.slave_raddr, 32'h1000000);
    do_burst(0, done);
    check("second_raddr", bus.slave_raddr, 32'h1000100);
    repeat (40) do_burst(int'($urandom_range(0, 5)), done);
    fb = 2'($urandom);
    pulse(fb);
    exp_bank = fb;
    exp_addr = 0;
    while (exp_addr != 'h1000) do_burst(0, done);
    do_burst(4, done);
    do_burst(0, done);
    do_burst(0, done);
    fb = 2'($urandom);
    pulse(fb);
    exp_bank = fb;
    exp_addr = 0;
    done = 1'b0;
    cnt  = 0;
    while (!done && cnt < 1000) begin
      do_burst(int'($urandom_range(0, 1)), done);
      cnt++;
    end
    check("bursts_per_frame", cnt, MAXA / BL);
    step(20);
    check("stays_idle_req", bus.slave_req, 0);
    check("stays_finished", bus.slave_frame_finished, 1);
    fb = 2'($urandom);
    pulse(fb);
    exp_bank = fb;
    exp_addr = 0;
    repeat (MAXA / BL - 1) do_burst(0, done);
    do_burst(5, done);
    check("restart_beats_done", bus.slave_frame_finished, 0);
    do_burst(0, done);
    wait_req();
`ifdef RD_TIMEOUT_EN
    step(65540);
    check("timeout_set", bus.slave_rd_timeout, 1);
    check("timeout_req", bus.slave_req, 0);
    check("timeout_finished", bus.slave_frame_finished, 1);
    pulse(2'b01);
    check("timeout_cleared", bus.slave_rd_timeout, 0);
`else
    step(50);
    check("timeout_absent", bus.slave_rd_timeout, 0);
    check("req_held", bus.slave_req, 1);
`endif
    pulse(2'b11);
    wait_req();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", bus.slave_req, 0);
    check("async_rst_finished", bus.slave_frame_finished, 1);
    check("async_rst_raddr", bus.slave_raddr, 0);
    rst_n = 1'b1;
    step(2);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
